shift_sub_div: RTL and testbench
================================

SHIFT_SUB_DIV -- requirements
Module: shift_sub_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 8-bit dividend, 4-bit divisor.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE or DONE.
REQ-005 a  input  8  dividend, same format as the 8-bit multiplier product.
REQ-006 b  input  4  divisor, same format as the multiplier operand.
REQ-007 q  output  8  quotient, registered.
REQ-008 r  output  4  remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; q and r are valid.
REQ-011 dz  output  1  divide-by-zero flag, registered.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE; DONE SHALL always return to IDLE unless start is accepted.
REQ-013 On an accepted start, a and b SHALL be captured; input changes after that edge SHALL be ignored until the next accepted start.
REQ-014 An accepted start with b!=0 SHALL enter CALC for exactly 8 cycles, then FIX for 1 cycle, then DONE for 1 cycle.
REQ-015 done SHALL therefore rise 10 clock edges after the start edge.
REQ-016 CALC SHALL use restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-017 The partial remainder in CALC SHALL be 5 bits wide to avoid compare overflow.
REQ-018 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-019 q, r and dz SHALL update only on entry to DONE and SHALL hold until the next accepted start or rst.
REQ-020 start asserted in CALC or FIX SHALL be ignored.
REQ-021 start asserted in DONE SHALL be accepted as back-to-back operation.
REQ-022 Divide by zero (b==0) SHALL skip CALC and FIX and go directly to DONE on the next edge.
REQ-023 For divide by zero, outputs SHALL be q=8'hFF, r=a[3:0], dz=1.
REQ-024 dz SHALL clear to 0 on the next accepted start.
REQ-025 For every non-zero divisor, the results SHALL satisfy a == q*b + r, with |r| < |b|.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and q=0, r=0, busy=0, done=0, dz=0.
REQ-027 rst SHALL override start.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-029 Macro DIV_SIGNED_EN SHALL select signed or unsigned operation.
REQ-030 With DIV_SIGNED_EN defined, a and b SHALL be two's complement.
REQ-031 In signed mode, FIX SHALL negate q when sign(a)^sign(b), and negate r when sign(a)=1 (truncating division).
REQ-032 In signed mode, -128/-1 SHALL wrap to q=8'h80, r=0.
REQ-033 Without DIV_SIGNED_EN, a and b SHALL be unsigned, and FIX SHALL pass q and r unchanged.
REQ-034 Latency SHALL be 10 edges in both modes.

Verification
REQ-035 Both modes: a=8'd100, b=4'd7, start pulse -> done 10 edges later, q=8'd14, r=4'd2, dz=0; busy high for 9 cycles.
REQ-036 a=8'h9C, b=4'd7 -> signed: q=8'hF2 (-14), r=4'hE (-2); unsigned: q=8'd22, r=4'd2.
REQ-037 a=8'h55, b=0 -> done 1 edge after start, q=8'hFF, r=4'h5, dz=1; next start with b=1 clears dz.
REQ-038 Signed: a=8'h80, b=4'hF -> q=8'h80, r=0. Unsigned: a=8'd128, b=4'd15 -> q=8'd8, r=4'd8.
REQ-039 start re-pulsed with a=8'd50, b=4'd3 during CALC cycle 3 of a 100/7 operation -> ignored; result remains 14 r 2.
REQ-040 rst pulsed in CALC cycle 4 -> outputs 0 on the next edge, no done pulse.
REQ-041 start held high through DONE -> second operation starts immediately; its done arrives 10 edges after the first done.

Source files
------------

// File: rtl/shift_sub_div_if.sv
// Request/result bundle for the shift_sub_div divider.
// The slave modport is the divider side and the master modport is the requester side.
interface shift_sub_div_if;
   logic       i_start;
   logic [7:0] i_a;
   logic [3:0] i_b;
   logic [7:0] o_q;
   logic [3:0] o_r;
   logic       o_busy;
   logic       o_done;
   logic       o_dz;

   modport slave (
      input  i_start, i_a, i_b,
      output o_q, o_r, o_busy, o_done, o_dz
   );

   modport master (
      output i_start, i_a, i_b,
      input  o_q, o_r, o_busy, o_done, o_dz
   );
endinterface

// File: rtl/shift_sub_div.sv
// 8-bit by 4-bit restoring shift-subtract divider with a fixed 10-edge latency.
// Define DIV_SIGNED_EN to get two's-complement truncating division; it is unsigned otherwise.
module shift_sub_div (
   input  logic              clk,
   input  logic              rst,
   shift_sub_div_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      r_state, w_nextState;
   logic [7:0]  r_dvd;
   logic [3:0]  r_div;
   logic [3:0]  r_rem;
   logic [2:0]  r_cnt;
   logic [7:0]  r_q;
   logic [3:0]  r_r;
   logic        r_dz;

   logic        w_accept;
   logic [4:0]  w_partial;
   logic [4:0]  w_diff;
   logic        w_ge;
   logic [7:0]  w_magA;
   logic [3:0]  w_magB;
   logic [7:0]  w_fixQ;
   logic [3:0]  w_fixR;

   assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.i_start;

   // Since r_rem < divisor, a non-negative difference always stays below 16,
   // so bit 4 of the 5-bit difference acts as the borrow of the trial compare.
   assign w_partial = {r_rem, r_dvd[7]};
   assign w_diff    = w_partial - {1'b0, r_div};
   assign w_ge      = ~w_diff[4];

`ifdef DIV_SIGNED_EN
   logic r_signA, r_signB;

   assign w_magA = bus.i_a[7] ? (~bus.i_a + 8'd1) : bus.i_a;
   assign w_magB = bus.i_b[3] ? (~bus.i_b + 4'd1) : bus.i_b;
   assign w_fixQ = (r_signA ^ r_signB) ? (~r_dvd + 8'd1) : r_dvd;
   assign w_fixR = r_signA ? (~r_rem + 4'd1) : r_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_signA <= 1'b0;
         r_signB <= 1'b0;
      end else if (w_accept) begin
         r_signA <= bus.i_a[7];
         r_signB <= bus.i_b[3];
      end
   end
`else
   assign w_magA = bus.i_a;
   assign w_magB = bus.i_b;
   assign w_fixQ = r_dvd;
   assign w_fixR = r_rem;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept) w_nextState = (bus.i_b == 4'd0) ? DONE : CALC;
            else          w_nextState = IDLE;
         end
         CALC:    if (r_cnt == 3'd7) w_nextState = FIX;
         FIX:     w_nextState = DONE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.o_busy = 1'b0;
      bus.o_done = 1'b0;
      case (r_state)
         CALC, FIX: bus.o_busy = 1'b1;
         DONE:      bus.o_done = 1'b1;
         default:   ;
      endcase
   end

   // The dividend register doubles as the quotient: each cycle a bit shifts out
   // the top into the partial remainder and a quotient bit shifts in at the bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dvd <= 8'd0;
         r_div <= 4'd0;
         r_rem <= 4'd0;
         r_cnt <= 3'd0;
         r_q   <= 8'd0;
         r_r   <= 4'd0;
         r_dz  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  r_dvd <= w_magA;
                  r_div <= w_magB;
                  r_rem <= 4'd0;
                  r_cnt <= 3'd0;
                  if (bus.i_b == 4'd0) begin
                     r_q  <= 8'hFF;
                     r_r  <= bus.i_a[3:0];
                     r_dz <= 1'b1;
                  end else begin
                     r_dz <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_dvd <= {r_dvd[6:0], w_ge};
               r_rem <= w_ge ? w_diff[3:0] : w_partial[3:0];
               r_cnt <= r_cnt + 3'd1;
            end
            FIX: begin
               r_q <= w_fixQ;
               r_r <= w_fixR;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_q  = r_q;
   assign bus.o_r  = r_r;
   assign bus.o_dz = r_dz;

endmodule

// File: tb/tb_shift_sub_div.sv
// Directed-vector bench for shift_sub_div; expectations follow DIV_SIGNED_EN when defined.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_sub_div;

   logic clk;
   logic rst;
   int   vecCount;
   int   errCount;

   shift_sub_div_if dut_if();

   shift_sub_div dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses start for one edge, scrambles the operands afterwards, and counts
   // edges (including the start edge) until done is seen, bounded at 40.
   task automatic applyStimulus(input logic [7:0] aIn, input logic [3:0] bIn,
                                output int edges, output int busyCycles);
      edges = 0;
      busyCycles = 0;
      @(negedge clk);
      dut_if.i_start = 1'b1;
      dut_if.i_a     = aIn;
      dut_if.i_b     = bIn;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         dut_if.i_start = 1'b0;
         dut_if.i_a     = 8'h3C;
         dut_if.i_b     = 4'd5;
         edges++;
         if (dut_if.o_busy) busyCycles++;
         if (dut_if.o_done) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dut_if.i_start = 1'b1;
      dut_if.i_a = 8'h55;
      dut_if.i_b = 4'd0;
      repeat (3) @(negedge clk);
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r} !== 12'h000) begin
         errCount++;
         $display("[TB] FAIL reset_qr: got q=%h r=%h expected q=00 r=0", dut_if.o_q, dut_if.o_r);
      end
      vecCount++;
      if ({dut_if.o_busy, dut_if.o_done, dut_if.o_dz} !== 3'b000) begin
         errCount++;
         $display("[TB] FAIL reset_flags: got busy/done/dz=%b expected 000",
                  {dut_if.o_busy, dut_if.o_done, dut_if.o_dz});
      end
      dut_if.i_start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int edges, busyCycles;
      applyStimulus(8'd100, 4'd7, edges, busyCycles);
      vecCount++;
      if (edges !== 10) begin
         errCount++;
         $display("[TB] FAIL basic_latency: got %0d edges expected 10", edges);
      end
      vecCount++;
      if (busyCycles !== 9) begin
         errCount++;
         $display("[TB] FAIL basic_busy: got %0d busy cycles expected 9", busyCycles);
      end
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r, dut_if.o_dz} !== {8'd14, 4'd2, 1'b0}) begin
         errCount++;
         $display("[TB] FAIL basic_result: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0",
                  dut_if.o_q, dut_if.o_r, dut_if.o_dz);
      end
      @(negedge clk);
      vecCount++;
      if ({dut_if.o_done, dut_if.o_q, dut_if.o_r} !== {1'b0, 8'd14, 4'd2}) begin
         errCount++;
         $display("[TB] FAIL basic_hold: got done=%b q=%0d r=%0d expected done=0 q=14 r=2",
                  dut_if.o_done, dut_if.o_q, dut_if.o_r);
      end
   endtask

   task automatic test_negative();
      int edges, busyCycles;
      logic [7:0] expQ;
      logic [3:0] expR;
`ifdef DIV_SIGNED_EN
      expQ = 8'hF2;
      expR = 4'hE;
`else
      expQ = 8'd22;
      expR = 4'd2;
`endif
      applyStimulus(8'h9C, 4'd7, edges, busyCycles);
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r} !== {expQ, expR} || edges !== 10) begin
         errCount++;
         $display("[TB] FAIL neg_dividend: got q=%h r=%h edges=%0d expected q=%h r=%h edges=10",
                  dut_if.o_q, dut_if.o_r, edges, expQ, expR);
      end
   endtask

   task automatic test_divzero();
      int edges, busyCycles;
      applyStimulus(8'h55, 4'd0, edges, busyCycles);
      vecCount++;
      if (edges !== 1 || busyCycles !== 0) begin
         errCount++;
         $display("[TB] FAIL dz_latency: got edges=%0d busy=%0d expected edges=1 busy=0", edges, busyCycles);
      end
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r, dut_if.o_dz} !== {8'hFF, 4'h5, 1'b1}) begin
         errCount++;
         $display("[TB] FAIL dz_result: got q=%h r=%h dz=%b expected q=FF r=5 dz=1",
                  dut_if.o_q, dut_if.o_r, dut_if.o_dz);
      end
      // Back-to-back from DONE with a legal divisor must clear dz at once.
      dut_if.i_start = 1'b1;
      dut_if.i_a = 8'h55;
      dut_if.i_b = 4'd1;
      @(negedge clk);
      dut_if.i_start = 1'b0;
      vecCount++;
      if ({dut_if.o_dz, dut_if.o_busy} !== 2'b01) begin
         errCount++;
         $display("[TB] FAIL dz_clear: got dz=%b busy=%b expected dz=0 busy=1", dut_if.o_dz, dut_if.o_busy);
      end
      for (int i = 0; i < 20 && !dut_if.o_done; i++) @(negedge clk);
      vecCount++;
      if ({dut_if.o_done, dut_if.o_q, dut_if.o_r, dut_if.o_dz} !== {1'b1, 8'h55, 4'h0, 1'b0}) begin
         errCount++;
         $display("[TB] FAIL dz_followup: got done=%b q=%h r=%h dz=%b expected done=1 q=55 r=0 dz=0",
                  dut_if.o_done, dut_if.o_q, dut_if.o_r, dut_if.o_dz);
      end
   endtask

   task automatic test_boundary();
      int edges, busyCycles;
      logic [7:0] expQ;
      logic [3:0] expR;
`ifdef DIV_SIGNED_EN
      expQ = 8'h80;
      expR = 4'h0;
`else
      expQ = 8'd8;
      expR = 4'd8;
`endif
      applyStimulus(8'h80, 4'hF, edges, busyCycles);
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r} !== {expQ, expR} || edges !== 10) begin
         errCount++;
         $display("[TB] FAIL boundary_80_F: got q=%h r=%h edges=%0d expected q=%h r=%h edges=10",
                  dut_if.o_q, dut_if.o_r, edges, expQ, expR);
      end
   endtask

   task automatic test_ignore_start();
      int edges;
      edges = 0;
      @(negedge clk);
      dut_if.i_start = 1'b1;
      dut_if.i_a = 8'd100;
      dut_if.i_b = 4'd7;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         edges++;
         if (edges == 3) begin
            dut_if.i_start = 1'b1;
            dut_if.i_a = 8'd50;
            dut_if.i_b = 4'd3;
         end else begin
            dut_if.i_start = 1'b0;
         end
         if (dut_if.o_done) break;
      end
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r} !== {8'd14, 4'd2} || edges !== 10) begin
         errCount++;
         $display("[TB] FAIL ignore_start: got q=%0d r=%0d edges=%0d expected q=14 r=2 edges=10",
                  dut_if.o_q, dut_if.o_r, edges);
      end
   endtask

   task automatic test_reset_mid();
      int doneSeen;
      doneSeen = 0;
      @(negedge clk);
      dut_if.i_start = 1'b1;
      dut_if.i_a = 8'd100;
      dut_if.i_b = 4'd7;
      @(negedge clk);
      dut_if.i_start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r, dut_if.o_busy, dut_if.o_done, dut_if.o_dz} !== 15'd0) begin
         errCount++;
         $display("[TB] FAIL reset_mid: got q=%h r=%h busy=%b done=%b dz=%b expected all zero",
                  dut_if.o_q, dut_if.o_r, dut_if.o_busy, dut_if.o_done, dut_if.o_dz);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (dut_if.o_done || dut_if.o_busy) doneSeen++;
      end
      vecCount++;
      if (doneSeen !== 0) begin
         errCount++;
         $display("[TB] FAIL reset_abort: got %0d active cycles after reset expected 0", doneSeen);
      end
   endtask

   task automatic test_back_to_back();
      int edges, gap;
      edges = 0;
      gap = 0;
      @(negedge clk);
      dut_if.i_start = 1'b1;
      dut_if.i_a = 8'd100;
      dut_if.i_b = 4'd7;
      for (int i = 0; i < 40 && !dut_if.o_done; i++) begin
         @(negedge clk);
         edges++;
      end
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r} !== {8'd14, 4'd2} || edges !== 10) begin
         errCount++;
         $display("[TB] FAIL b2b_first: got q=%0d r=%0d edges=%0d expected q=14 r=2 edges=10",
                  dut_if.o_q, dut_if.o_r, edges);
      end
      dut_if.i_a = 8'd50;
      dut_if.i_b = 4'd3;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         dut_if.i_start = 1'b0;
         gap++;
         if (dut_if.o_done) break;
      end
      vecCount++;
      if ({dut_if.o_q, dut_if.o_r} !== {8'd16, 4'd2} || gap !== 10) begin
         errCount++;
         $display("[TB] FAIL b2b_second: got q=%0d r=%0d gap=%0d expected q=16 r=2 gap=10",
                  dut_if.o_q, dut_if.o_r, gap);
      end
   endtask

   initial begin
      vecCount = 0;
      errCount = 0;
      rst = 1'b0;
      dut_if.i_start = 1'b0;
      dut_if.i_a = 8'd0;
      dut_if.i_b = 4'd0;
      test_reset();
      test_basic();
      test_negative();
      test_divzero();
      test_boundary();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
